// File: rtl/adder_arb_if.sv
// Bundle between adder_arb, its client engines (requester side) and the shared adder tree.
// Packed operand arrays share the flat layout: requester r, operand k at [(r*NUM+k)*BITS +: BITS].
interface adder_arb_if #(
  parameter int BITS = 8,
  parameter int NUM  = 8,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]                      req_valid;
  logic [NREQ-1:0]                      req_ready;
  logic [NREQ-1:0][NUM-1:0][BITS-1:0]   req_data;
  logic                                 add_valid;
  logic [NUM-1:0][BITS-1:0]             add_i;
  logic [BITS-1:0]                      add_o;
  logic                                 add_valid_out;
  logic [NREQ-1:0]                      rsp_valid;
  logic [BITS-1:0]                      rsp_data;
  logic                                 err;

  modport slave (
    input  req_valid, req_data, add_o, add_valid_out,
    output req_ready, add_valid, add_i, rsp_valid, rsp_data, err
  );
  modport master (
    output req_valid, req_data, add_o, add_valid_out,
    input  req_ready, add_valid, add_i, rsp_valid, rsp_data, err
  );
endinterface

// File: rtl/adder_arb.sv
// Round-robin front end sharing one pipelined adder tree among NREQ requesters.
// Optional ADDER_ARB_CHECK_EN adds a sticky err flag for result/tag misalignment.
module adder_arb #(
  parameter int BITS = 8,
  parameter int NUM  = 8,
  parameter int NREQ = 4,
  parameter int LAT  = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  adder_arb_if.slave   bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]            ptr;
  logic [IW-1:0]            gnt_id;
  logic                     gnt_any;
  logic [NREQ-1:0]          gnt;
  logic                     add_valid_q;
  logic [NUM-1:0][BITS-1:0] add_i_q;
  logic [NREQ-1:0]          rsp_valid_q;
  logic [BITS-1:0]          rsp_data_q;
  logic [LAT:0][IW-1:0]     tag_id;
  logic [NREQ-1:0]          rsp_oh;

  // First valid requester at or after ptr, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    if (en) begin
      for (int i = 0; i < NREQ; i++) begin
        idx = int'(ptr) + i;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!gnt_any && bus.req_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_id  = IW'(idx);
        end
      end
    end
    if (gnt_any) gnt[gnt_id] = 1'b1;
  end

  assign bus.req_ready = gnt & {NREQ{rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      add_valid_q <= 1'b0;
      add_i_q     <= '0;
    end else begin
      add_valid_q <= gnt_any;
      if (gnt_any) begin
        add_i_q <= bus.req_data[gnt_id];
        ptr     <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
      end
    end
  end

  // Stage 0 runs alongside add_valid; stage LAT lines up with add_valid_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag_id <= '0;
    else        tag_id <= {tag_id[LAT-1:0], gnt_id};
  end

  assign rsp_oh = NREQ'(1) << tag_id[LAT];

`ifdef ADDER_ARB_CHECK_EN
  logic [LAT:0] tag_v;
  logic         err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v       <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      tag_v <= {tag_v[LAT-1:0], gnt_any};
      if (bus.add_valid_out != tag_v[LAT]) err_q <= 1'b1;
      rsp_valid_q <= (bus.add_valid_out && tag_v[LAT]) ? rsp_oh : '0;
      if (bus.add_valid_out) rsp_data_q <= bus.add_o;
    end
  end

  assign bus.err = err_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= bus.add_valid_out ? rsp_oh : '0;
      if (bus.add_valid_out) rsp_data_q <= bus.add_o;
    end
  end

  assign bus.err = 1'b0;
`endif

  assign bus.add_valid = add_valid_q;
  assign bus.add_i     = add_i_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
endmodule
